// File: rtl/bit_count_initiator_if.sv
// Command/done handshake bundle between the bit-count initiator (master) and its
// responder (slave): operand and request go out, done and ones count come back.
interface bit_count_initiator_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 3
) ();
  logic              command;
  logic [DATA_W-1:0] dataA;
  logic              done;
  logic [CNT_W-1:0]  ones_in;

  modport master (output command, output dataA, input done, input ones_in);
  modport slave  (input command, input dataA, output done, output ones_in);
endinterface

// File: rtl/bit_count_initiator.sv
// Initiator of the command/done bit-count handshake: sends NUM_WORDS operands from seed and
// accumulates the responder's ones counts. Define BIT_COUNT_SELF_CHECK_EN for popcount self-check.
module bit_count_initiator #(
  parameter int DATA_W      = 4,
  parameter int CNT_W       = 3,
  parameter int NUM_WORDS   = 8,
  parameter int TOT_W       = 6,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     seed,
  bit_count_initiator_if.master bus,
  output logic                  busy,
  output logic                  finished,
  output logic [2:0]            word_idx,
  output logic [TOT_W-1:0]      total_ones,
  output logic [3:0]            err_count,
  output logic                  timeout_flag
);

  localparam int SET_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, REQ, WAIT_DONE, RELEASE, WAIT_LOW, ABORT
  } state_t;

  state_t           state, state_next;
  logic [SET_W-1:0] setup_cnt;
  logic [TMR_W-1:0] timer;

  logic run_load, cmd_set, cmd_clr, capture, advance, run_end, run_abort;
  logic setup_inc, timer_clr, timer_inc;
  logic timer_hit, last_word;

  assign timer_hit = (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign last_word = (word_idx == 3'(NUM_WORDS - 1));

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    run_load   = 1'b0;
    cmd_set    = 1'b0;
    cmd_clr    = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    run_end    = 1'b0;
    run_abort  = 1'b0;
    setup_inc  = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          run_load   = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt == SET_W'(SETUP_CYC - 1)) begin
          cmd_set    = 1'b1;
          state_next = REQ;
        end else begin
          setup_inc = 1'b1;
        end
      end
      REQ: begin
        timer_clr  = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done already high on entry is taken on the first cycle.
        if (bus.done) begin
          capture    = 1'b1;
          state_next = RELEASE;
        end else if (timer_hit) begin
          state_next = ABORT;
        end else begin
          timer_inc = 1'b1;
        end
      end
      RELEASE: begin
        cmd_clr    = 1'b1;
        timer_clr  = 1'b1;
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.done) begin
          if (last_word) begin
            run_end    = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = SETUP;
          end
        end else if (timer_hit) begin
          state_next = ABORT;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ABORT: begin
        run_abort  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      bus.command  <= 1'b0;
      bus.dataA    <= '0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      timeout_flag <= 1'b0;
      word_idx     <= '0;
      total_ones   <= '0;
      setup_cnt    <= '0;
      timer        <= '0;
    end else begin
      if (run_load) begin
        bus.dataA    <= seed;
        word_idx     <= '0;
        total_ones   <= '0;
        finished     <= 1'b0;
        timeout_flag <= 1'b0;
        busy         <= 1'b1;
      end
      // Operand only moves once both command and done are low again.
      if (advance) begin
        word_idx  <= word_idx + 3'd1;
        bus.dataA <= bus.dataA + DATA_W'(1);
      end
      if (capture)
        total_ones <= total_ones + TOT_W'(bus.ones_in);
      if (cmd_set)
        bus.command <= 1'b1;
      if (cmd_clr || run_abort)
        bus.command <= 1'b0;
      if (run_end) begin
        busy     <= 1'b0;
        finished <= 1'b1;
      end
      if (run_abort) begin
        busy         <= 1'b0;
        finished     <= 1'b1;
        timeout_flag <= 1'b1;
      end
      if (run_load || advance)
        setup_cnt <= '0;
      else if (setup_inc)
        setup_cnt <= setup_cnt + SET_W'(1);
      if (timer_clr)
        timer <= '0;
      else if (timer_inc)
        timer <= timer + TMR_W'(1);
    end
  end

`ifdef BIT_COUNT_SELF_CHECK_EN
  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++)
      n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset)
      err_count <= '0;
    else if (run_load)
      err_count <= '0;
    else if (capture && (bus.ones_in != popcount(bus.dataA)))
      err_count <= sat_inc(err_count);
  end
`else
  assign err_count = 4'd0;
`endif

endmodule
